// File: rtl/enc83_pkg.sv
// rtl/enc83_pkg.sv - shared types, widths and helpers for the sequential 8-to-3 encoder
//   Contents: enc83_state_t (IDLE, SEND), ENC83_LINES, ENC83_CODE_W, popcount8()
package enc83_pkg;

    localparam int ENC83_LINES  = 8;
    localparam int ENC83_CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } enc83_state_t;

    function automatic logic [3:0] popcount8(input logic [ENC83_LINES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < ENC83_LINES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/enc83_prio.sv
// rtl/enc83_prio.sv - combinational highest-set-bit finder
//   Ports: vec (8-bit line vector) -> idx (index of highest set bit, 0 when vec is zero),
//          zero (vec has no set bit), single (vec has exactly one set bit)
module enc83_prio
    import enc83_pkg::*;
(
    input  logic [ENC83_LINES-1:0]  vec,
    output logic [ENC83_CODE_W-1:0] idx,
    output logic                    zero,
    output logic                    single
);

    localparam logic [ENC83_LINES-1:0] ONE = 1;

    always_comb begin
        idx = '0;
        // Ascending scan: a later (higher) set bit overrides, leaving the highest.
        for (int i = 0; i < ENC83_LINES; i++) begin
            if (vec[i]) begin
                idx = i[ENC83_CODE_W-1:0];
            end
        end
        zero   = (vec == '0);
        // v & (v-1) clears the lowest set bit; zero result means at most one bit.
        single = !zero && ((vec & (vec - ONE)) == '0);
    end

endmodule

// File: rtl/enc83_seq.sv
// rtl/enc83_seq.sv - sequential 8-to-3 encoder, serializes set lines highest first
//   Ports: clk, rst_n (async, active-low)
//          in_valid/in_ready/d/e  - vector input handshake; e=0 treats d as zero
//          out_valid/out_ready/a/none/last - code output stream
//          count - popcount of accepted vector, only when ENC83_COUNT_EN is defined
module enc83_seq
    import enc83_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ENC83_LINES-1:0]  d,
    input  logic                    e,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ENC83_CODE_W-1:0] a,
    output logic                    none,
    output logic                    last
`ifdef ENC83_COUNT_EN
    ,
    output logic [3:0]              count
`endif
);

    localparam logic [ENC83_LINES-1:0] ONE = 1;

    enc83_state_t            state, state_nxt;
    logic [ENC83_LINES-1:0]  pend, pend_nxt;
    logic [ENC83_LINES-1:0]  eff;
    logic [ENC83_CODE_W-1:0] hi_idx;
    logic                    hi_zero, hi_single;
    logic                    accept;

    assign eff = e ? d : '0;

    enc83_prio u_prio (
        .vec    (pend),
        .idx    (hi_idx),
        .zero   (hi_zero),
        .single (hi_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

`ifdef ENC83_COUNT_EN
    // Loaded only on accept, so it stays put across every beat of the vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept) begin
            count <= popcount8(eff);
        end
    end
`endif

    // Outputs depend only on state and pend, never on the inputs.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        a         = '0;
        none      = 1'b0;
        last      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    pend_nxt  = eff;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                a         = hi_idx;
                none      = hi_zero;
                last      = hi_zero || hi_single;
                if (out_ready) begin
                    pend_nxt = pend & ~(ONE << hi_idx);
                    if (hi_zero || hi_single) begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_enc83_seq.sv
// tb/tb_enc83_seq.sv - self-checking bench for enc83_seq (optional ENC83_COUNT_EN)
module tb_enc83_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       e;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] a;
    logic       none;
    logic       last;
`ifdef ENC83_COUNT_EN
    logic [3:0] count;
`endif

    int npass  = 0;
    int ntotal = 0;

    enc83_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .e         (e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .none      (none),
        .last      (last)
`ifdef ENC83_COUNT_EN
        ,
        .count     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one vector and consumes its beats. rdy_pct sets out_ready probability;
    // junk in_valid pulses and random d/e are driven during SEND and must be ignored.
    task automatic send_vec(input string tag, input logic [7:0] dv, input logic ev,
                            input int rdy_pct);
        int        exp_a[$];
        logic      exp_none;
        int        pop;
        int        k;
        int        budget;
        logic [7:0] effv;
        effv = ev ? dv : 8'h00;
        pop  = 0;
        for (int i = 7; i >= 0; i--) begin
            if (effv[i]) begin
                exp_a.push_back(i);
                pop++;
            end
        end
        exp_none = (pop == 0);
        if (exp_none) exp_a.push_back(0);

        chk({tag, "_in_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        d        = dv;
        e        = ev;
        tick();
        k      = 0;
        budget = 200;
        while (k < exp_a.size() && budget > 0) begin
            chk({tag, "_out_valid"}, out_valid, 1);
            chk({tag, "_in_ready_busy"}, in_ready, 0);
            chk({tag, "_a"}, a, exp_a[k]);
            chk({tag, "_none"}, none, exp_none);
            chk({tag, "_last"}, last, (k == exp_a.size() - 1));
`ifdef ENC83_COUNT_EN
            chk({tag, "_count"}, count, pop);
`endif
            in_valid  = ($urandom_range(0, 3) == 0);
            d         = 8'($urandom);
            e         = 1'($urandom);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            tick();
            if (out_ready) k++;
            budget--;
        end
        chk({tag, "_beats_done"}, k, exp_a.size());
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, out_valid, 0);
        chk({tag, "_idle_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        d         = 8'h00;
        e         = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a", a, 0);
        chk("rst_none", none, 0);
        chk("rst_last", last, 0);
`ifdef ENC83_COUNT_EN
        chk("rst_count", count, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Single line: in_ready back two cycles after accept
        in_valid = 1'b1; d = 8'h08; e = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_a", a, 3);
        chk("single_last", last, 1);
        chk("single_none", none, 0);
        chk("single_in_ready_c1", in_ready, 0);
        tick();
        chk("single_in_ready_c2", in_ready, 1);
        chk("single_done", out_valid, 0);
        out_ready = 1'b0;

        // Directed patterns with full throughput
        send_vec("multi_a5", 8'hA5, 1'b1, 100);
        send_vec("dis_ff", 8'hFF, 1'b0, 100);
        send_vec("zero_00", 8'h00, 1'b1, 100);
        send_vec("all_ff", 8'hFF, 1'b1, 100);
        send_vec("top_80", 8'h80, 1'b1, 100);
        send_vec("bot_01", 8'h01, 1'b1, 100);

        // Backpressure with ignored in_valid pulses
        in_valid = 1'b1; d = 8'h81; e = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            d        = 8'h7E;
            chk("bp_hold_a", a, 7);
            chk("bp_hold_last", last, 0);
            chk("bp_hold_valid", out_valid, 1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_a7", a, 7);
        tick();
        chk("bp_a0", a, 0);
        chk("bp_last", last, 1);
        tick();
        chk("bp_idle", out_valid, 0);
        out_ready = 1'b0;

        // Back-to-back: in_valid held high
        in_valid = 1'b1; d = 8'h03; e = 1'b1; out_ready = 1'b1;
        tick();
        d = 8'h40;
        chk("b2b_a1", a, 1);
        tick();
        chk("b2b_a0", a, 0);
        chk("b2b_last0", last, 1);
        tick();
        chk("b2b_gap_in_ready", in_ready, 1);
        chk("b2b_gap_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("b2b_a6", a, 6);
        chk("b2b_last6", last, 1);
        tick();
        chk("b2b_end", out_valid, 0);
        out_ready = 1'b0;

        // Random vectors against the model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rv;
            rv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send_vec("rand", rv, ($urandom_range(0, 5) != 0), 60);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Reset mid-SEND
        in_valid = 1'b1; d = 8'hFF; e = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_pre_a", a, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_a", a, 0);
        chk("mid_rst_last", last, 0);
        chk("mid_rst_none", none, 0);
`ifdef ENC83_COUNT_EN
        chk("mid_rst_count", count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_post_out_valid", out_valid, 0);
            chk("mid_post_in_ready", in_ready, 1);
        end
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/enc83_seq.md
# enc83_seq

Sequential 8-to-3 encoder: the reverse path of the team's 3-to-8 decoder. It accepts an 8-bit line vector with an enable and serializes every asserted line, highest index first, as 3-bit codes on a valid/ready stream. It sits between line-level request sources and any consumer that expects decoder-format `{e,a}` codes.

## Interface
Parameters: none. Width is fixed at 8 lines / 3-bit code.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  reset; asynchronous assert, active-low.
- `in_valid`  input  1  `d`/`e` present.
- `in_ready`  output  1  block can accept a vector.
- `d`  input  8  line vector; bit i set → code i emitted.
- `e`  input  1  enable; 0 → vector treated as all-zero.
- `out_valid`  output  1  `a`/`none`/`last` valid.
- `out_ready`  input  1  consumer takes current beat.
- `a`  output  3  encoded line index.
- `none`  output  1  beat carries no line (zero vector or `e`=0).
- `last`  output  1  final beat for the accepted vector.
- `count`  output  4  popcount of accepted effective vector. Present only with `ENC83_COUNT_EN`.

## Operation
- States: `IDLE`, `SEND`.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`, latch `pend = e ? d : 8'h00` and go to `SEND`.
- **SEND**
  - `in_ready`=0, `out_valid`=1.
  - `a` = index of highest set bit of `pend`.
  - `last` = 1 when `pend` has at most one set bit.
  - `none` = 1 when `pend` = 0; in that case `a` = 0 and `last` = 1.
- Beat completes on `out_valid && out_ready`.
  - Clear the highest set bit of `pend`.
  - If `last` is set, go to `IDLE`; otherwise stay in `SEND`.
- Backpressure: while `out_valid && !out_ready`, `a`, `none`, `last` and `count` are held stable.
- Inputs `d` and `e` are ignored outside the accept cycle.
- Number of beats per vector = max(1, popcount).
- Reset mid-stream discards `pend`; no further beats are emitted for that vector.

## Timing
- Reset values:
  - state = `IDLE`
  - `pend` = 0
  - `in_ready` = 1
  - `out_valid` = 0
  - `a` = 0
  - `none` = 0
  - `last` = 0
  - `count` = 0
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.
- Latency: first beat `out_valid` is asserted the cycle after the accept edge.
- With `out_ready` held high, one beat per cycle.
- `in_ready` rises the cycle after the `last` handshake.
- Throughput: popcount + 1 cycles per vector (minimum 2).
- No same-cycle accept while in `SEND`. The simultaneous `in_valid` and last-beat handshake case resolves to: the beat completes, and the new vector is accepted in the following `IDLE` cycle.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Configuration
- Macro: `ENC83_COUNT_EN`.
- Defined:
  - `count` port exists.
  - Loaded at accept with the popcount of the effective vector (0..8).
  - Held constant through all beats of that vector.
  - Reset to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package `enc83_pkg`:
  - state enum (`IDLE`, `SEND`)
  - width constants `ENC83_LINES` = 8 and `ENC83_CODE_W` = 3
- Natural sub-module: `enc83_prio`, a combinational highest-set-bit finder.
  - Input: 8-bit vector.
  - Outputs: 3-bit index, `zero`, `single`.
  - The top level holds the FSM, `pend` and the handshake.

## Test plan
- Reset mid-`SEND`:
  - Accept 8'hFF, take 3 beats, assert `rst_n`=0 asynchronously.
  - Outputs return to reset values immediately.
  - After release, `in_ready`=1 and no residual beats appear.
- Single line:
  - `d`=8'h08, `e`=1, `out_ready`=1.
  - One beat: `a`=3, `last`=1, `none`=0.
  - `in_ready` returns 2 cycles after accept.
- Multi line, priority order:
  - `d`=8'hA5, `e`=1.
  - Beats: `a`=7, 5, 2, 0; `last` set only on the 4th beat.
  - With `ENC83_COUNT_EN`, `count`=4 on all beats.
- Disabled and zero cases:
  - `d`=8'hFF with `e`=0 → one beat: `none`=1, `a`=0, `last`=1 (`count`=0).
  - `d`=8'h00 with `e`=1 → same response.
- Backpressure:
  - `d`=8'h81, `out_ready` low for 5 cycles.
  - `a`=7 holds stable; `in_valid` pulses are ignored.
  - Then `out_ready`=1 yields `a`=7, then `a`=0 with `last`=1.
- Back-to-back vectors:
  - `in_valid` held high with 8'h03, then 8'h40.
  - Second vector is accepted exactly one cycle after the `last` handshake of the first.
  - Beats: 1, 0, then 6.
